// File: rtl/jtcop_mcu_mbox_if.sv
// Bus bundle between the 68000 mailbox select / i8751 port strobes and the mailbox.
// The mailbox uses the slave modport; whoever drives the CPU and MCU side uses master.
interface jtcop_mcu_mbox_if;
  logic        cpu_cs;
  logic        cpu_addr;
  logic        cpu_rnw;
  logic [1:0]  cpu_dsn;
  logic [15:0] cpu_dout;
  logic [15:0] cpu_din;
  logic [7:0]  mcu_p0o;
  logic        mcu_rdhi;
  logic        mcu_rdlo;
  logic        mcu_wrhi;
  logic        mcu_wrlo;
  logic        mcu_intack_n;
  logic [7:0]  mcu_p0i;
  logic        mcu_intn;
  logic        nexirq;

  modport master (
    output cpu_cs, cpu_addr, cpu_rnw, cpu_dsn, cpu_dout,
    output mcu_p0o, mcu_rdhi, mcu_rdlo, mcu_wrhi, mcu_wrlo, mcu_intack_n,
    input  cpu_din, mcu_p0i, mcu_intn, nexirq
  );

  modport slave (
    input  cpu_cs, cpu_addr, cpu_rnw, cpu_dsn, cpu_dout,
    input  mcu_p0o, mcu_rdhi, mcu_rdlo, mcu_wrhi, mcu_wrlo, mcu_intack_n,
    output cpu_din, mcu_p0i, mcu_intn, nexirq
  );
endinterface

// File: rtl/jtcop_mcu_mbox.sv
// 68000-side command/response mailbox towards the i8751 MCU.
// Optional command watchdog enabled by defining JTCOP_MBOX_TIMEOUT_EN.
module jtcop_mcu_mbox #(
  parameter bit IRQ_EN = 1'b1,
  parameter int TOUT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  jtcop_mcu_mbox_if.slave  bus
);

  logic [15:0] r_cmd, r_resp, r_din;
  logic [7:0]  r_p0i;
  logic        r_cmd_full, r_resp_full, r_ovr, r_intn, r_nexirq;
  logic        r_cs_d, r_rdhi_d, r_rdlo_d, r_wrhi_d, r_wrlo_d;

  logic w_act, w_dwr, w_swr, w_drd, w_srd;
  logic w_rdhi, w_rdlo, w_wrhi, w_wrlo;
  logic w_expire, w_tout;

  // One action per bus cycle: only the rising edge of the select counts
  assign w_act  = bus.cpu_cs & ~r_cs_d;
  assign w_dwr  = w_act & ~bus.cpu_rnw & ~bus.cpu_addr;
  assign w_swr  = w_act & ~bus.cpu_rnw &  bus.cpu_addr;
  assign w_drd  = w_act &  bus.cpu_rnw & ~bus.cpu_addr;
  assign w_srd  = w_act &  bus.cpu_rnw &  bus.cpu_addr;

  assign w_rdhi = bus.mcu_rdhi & ~r_rdhi_d;
  assign w_rdlo = bus.mcu_rdlo & ~r_rdlo_d;
  assign w_wrhi = bus.mcu_wrhi & ~r_wrhi_d;
  assign w_wrlo = bus.mcu_wrlo & ~r_wrlo_d;

`ifdef JTCOP_MBOX_TIMEOUT_EN
  logic [TOUT_W-1:0] r_tcnt, w_tnext;
  logic              r_tout;

  assign w_tnext  = r_tcnt + 1'b1;
  // Expiry is the cycle the counter reaches all-ones; a fresh write or a final
  // low-byte read in that same cycle takes precedence
  assign w_expire = r_cmd_full & (&w_tnext) & ~w_dwr & ~w_rdlo;
  assign w_tout   = r_tout;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tcnt <= '0;
      r_tout <= 1'b0;
    end else begin
      if (w_dwr || !r_cmd_full || w_expire) r_tcnt <= '0;
      else                                 r_tcnt <= w_tnext;
      if (w_swr && bus.cpu_dout[3]) r_tout <= 1'b0;
      if (w_expire)                 r_tout <= 1'b1;
    end
  end
`else
  logic [TOUT_W-1:0] w_tout_unused;
  assign w_tout_unused = '0;
  assign w_expire      = 1'b0;
  assign w_tout        = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cs_d   <= 1'b0;
      r_rdhi_d <= 1'b0;
      r_rdlo_d <= 1'b0;
      r_wrhi_d <= 1'b0;
      r_wrlo_d <= 1'b0;
    end else begin
      r_cs_d   <= bus.cpu_cs;
      r_rdhi_d <= bus.mcu_rdhi;
      r_rdlo_d <= bus.mcu_rdlo;
      r_wrhi_d <= bus.mcu_wrhi;
      r_wrlo_d <= bus.mcu_wrlo;
    end
  end

  // Later assignments win: the statement order encodes collision priority
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cmd       <= 16'd0;
      r_resp      <= 16'd0;
      r_din       <= 16'd0;
      r_p0i       <= 8'd0;
      r_cmd_full  <= 1'b0;
      r_resp_full <= 1'b0;
      r_ovr       <= 1'b0;
      r_intn      <= 1'b1;
      r_nexirq    <= 1'b1;
    end else begin
      if (!bus.mcu_intack_n) r_intn <= 1'b1;
      if (w_rdhi) r_p0i <= r_cmd[15:8];
      if (w_rdlo) begin
        r_p0i      <= r_cmd[7:0];
        r_cmd_full <= 1'b0;
      end
      if (w_expire) begin
        r_cmd_full <= 1'b0;
        r_intn     <= 1'b1;
      end
      if (w_wrhi) r_resp[15:8] <= bus.mcu_p0o;
      if (w_dwr) begin
        if (!bus.cpu_dsn[1]) r_cmd[15:8] <= bus.cpu_dout[15:8];
        if (!bus.cpu_dsn[0]) r_cmd[7:0]  <= bus.cpu_dout[7:0];
        r_cmd_full <= 1'b1;
        r_intn     <= 1'b0;
        if (r_cmd_full) r_ovr <= 1'b1;
      end
      if (w_swr && bus.cpu_dout[2]) r_ovr <= 1'b0;
      if (w_drd) begin
        r_din       <= r_resp;
        r_resp_full <= 1'b0;
        r_nexirq    <= 1'b1;
      end
      if (w_srd) r_din <= {12'd0, w_tout, r_ovr, r_resp_full, r_cmd_full};
      if (w_wrlo) begin
        r_resp[7:0] <= bus.mcu_p0o;
        r_resp_full <= 1'b1;
        if (IRQ_EN) r_nexirq <= 1'b0;
      end
    end
  end

  assign bus.cpu_din  = r_din;
  assign bus.mcu_p0i  = r_p0i;
  assign bus.mcu_intn = r_intn;
  assign bus.nexirq   = r_nexirq;

endmodule
